// File: rtl/fb_pkg.sv
// Shared constants for the waterfall frame buffer: geometry, widths and the
// scheduler state encodings.
package fb_pkg;

  localparam int H_RES  = 320;
  localparam int V_RES  = 240;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int PIXELS = H_RES * V_RES;

  localparam logic [1:0] ST_CLEAR    = 2'd0;
  localparam logic [1:0] ST_VIDEO    = 2'd1;
  localparam logic [1:0] ST_WRITE    = 2'd2;
  localparam logic [1:0] ST_WAIT_END = 2'd3;

endpackage

// File: rtl/fb_row_addr.sv
// Frame buffer address generator: wraps (row + offset) into 0..V_RES-1 and
// returns wrapped_row*H_RES + col.
//   row    in  8       unscrolled row index
//   offset in  8       circular row offset (0..V_RES-1)
//   col    in  9       column index
//   addr   out ADDR_W  linear RAM address
module fb_row_addr
  import fb_pkg::*;
(
  input  logic [7:0]        row,
  input  logic [7:0]        offset,
  input  logic [8:0]        col,
  output logic [ADDR_W-1:0] addr
);

  logic [8:0]        sum;
  logic [8:0]        sum_wrapped;
  logic [ADDR_W-1:0] row_ext;

  always_comb begin
    sum = {1'b0, row} + {1'b0, offset};
    // both operands are below V_RES, so one subtraction always suffices
    if (sum >= 9'(V_RES)) sum_wrapped = sum - 9'(V_RES);
    else                  sum_wrapped = sum;
    row_ext = ADDR_W'(sum_wrapped);
    // row*320 as row*256 + row*64
    addr = (row_ext << 8) + (row_ext << 6) + ADDR_W'(col);
  end

endmodule

// File: rtl/fb_scheduler.sv
// Frame buffer scheduler: sole owner of the single-port frame buffer RAM,
// time-sharing it between the clear engine, the scrolled LCD read path and
// the waterfall line writer.
//   clk, reset               pixel clock, async active-high reset
//   visible, lower_blank, x, y   LCD driver timing and position
//   clear_req                single-cycle full clear request
//   wr_valid/wr_data/wr_last/wr_ready   line writer stream
//   ram_addr/ram_wdata/ram_we           registered RAM port
//   y_offset                 row shown at the top of the screen
//   busy                     high while clearing
//   line_err                 sticky line writer error
//
// state    | meaning
// ---------+------------------------------------------------------------
// CLEAR    | write zero to every pixel, one per cycle
// VIDEO    | RAM serves the LCD read path; waits for the scroll frame
// WRITE    | accepting the new row during lower blanking
// WAIT_END | row done, waiting for lower blanking to end
module fb_scheduler
  import fb_pkg::*;
#(
  parameter int SCROLL_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              visible,
  input  logic              lower_blank,
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic              clear_req,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [7:0]        y_offset,
  output logic              busy,
  output logic              line_err
);

  localparam int                FC_W     = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(SCROLL_DIV - 1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(PIXELS - 1);
  localparam logic [8:0]        COL_LAST = 9'(H_RES - 1);
  localparam logic [7:0]        ROW_LAST = 8'(V_RES - 1);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [ADDR_W-1:0] clr_addr;
  logic [8:0]        col;
  logic [7:0]        wrow;
  logic [FC_W-1:0]   frame_cnt;
  logic              lb_d;
  logic              clear_pend;

  logic              lb_rise;
  logic              beat;
  logic              clear_go;
  logic              frame_wrap;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  fb_row_addr u_rd_addr (
    .row    (y),
    .offset (y_offset),
    .col    (x),
    .addr   (rd_addr)
  );

  // wrow is always in range, so a zero offset makes the wrap a no-op
  fb_row_addr u_wr_addr (
    .row    (wrow),
    .offset (8'd0),
    .col    (col),
    .addr   (wr_addr)
  );

  always_comb begin
    lb_rise    = lower_blank & ~lb_d;
    // a beat offered in the cycle blanking ends is refused: video wins
    beat       = (state == ST_WRITE) && lower_blank && wr_valid && wr_ready;
    clear_go   = clear_pend | clear_req;
    frame_wrap = lb_rise && (frame_cnt == FC_LAST);
    next_state = state;
    case (state)
      ST_CLEAR:    if (!clear_req && clr_addr == CLR_LAST) next_state = ST_VIDEO;
      ST_VIDEO:    if (clear_go)        next_state = ST_CLEAR;
                   else if (frame_wrap) next_state = ST_WRITE;
      ST_WRITE:    if (!lower_blank)    next_state = ST_VIDEO;
                   else if (beat && col == COL_LAST) next_state = ST_WAIT_END;
      ST_WAIT_END: if (!lower_blank)    next_state = ST_VIDEO;
      default:     next_state = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      col        <= '0;
      wrow       <= '0;
      frame_cnt  <= '0;
      lb_d       <= 1'b0;
      clear_pend <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      y_offset   <= '0;
      busy       <= 1'b1;
      line_err   <= 1'b0;
      wr_ready   <= 1'b0;
    end else begin
      state     <= next_state;
      lb_d      <= lower_blank;
      wr_ready  <= (next_state == ST_WRITE);
      // busy covers the last clear write, dropping together with ram_we
      busy      <= (state == ST_CLEAR) || (next_state == ST_CLEAR);
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      ram_addr  <= visible ? rd_addr : '0;

      if (next_state == ST_CLEAR)  clear_pend <= 1'b0;
      else if (clear_req)          clear_pend <= 1'b1;

      if (next_state == ST_CLEAR && state != ST_CLEAR) begin
        clr_addr <= '0;
        y_offset <= '0;
      end

      case (state)
        ST_CLEAR: begin
          if (clear_req) begin
            clr_addr <= '0;
          end else begin
            ram_addr <= clr_addr;
            ram_we   <= 1'b1;
            clr_addr <= clr_addr + 1'b1;
          end
        end
        ST_VIDEO: begin
          if (!clear_go && lb_rise) begin
            if (frame_wrap) begin
              frame_cnt <= '0;
              col       <= '0;
              wrow      <= (y_offset == 8'd0) ? ROW_LAST : y_offset - 8'd1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (!lower_blank) begin
            line_err <= 1'b1;
          end else if (beat) begin
            ram_addr  <= wr_addr;
            ram_wdata <= wr_data;
            ram_we    <= 1'b1;
            col       <= col + 1'b1;
            if (wr_last != (col == COL_LAST)) line_err <= 1'b1;
            if (col == COL_LAST) y_offset <= wrow;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fb_scheduler.md
# fb_scheduler

Sole owner of the single-port 320x240x8 waterfall frame buffer RAM. It time-shares the RAM between three users: the power-up/requested clear engine, the LCD video read path (x/y from the LCD driver, scrolled by a circular row offset), and a line-writer client that streams one new waterfall row during the lower blanking interval every SCROLL_DIV frames. It sits between the LCD driver, the sample/line generator and the `ram` instance, and replaces ad-hoc address muxing in the top level.

## Interface
- H_RES, 320, pixels per row
- V_RES, 240, rows per frame
- ADDR_W, 17, RAM address width (must hold H_RES*V_RES-1)
- DATA_W, 8, pixel width
- SCROLL_DIV, 4, frames per new row (≥1)

- clk  in  1  pixel clock; one clock, all logic on its rising edge
- reset  in  1  asynchronous, active-high
- visible  in  1  LCD driver: current x/y is in the active area
- lower_blank  in  1  LCD driver: lower vertical blanking window
- x  in  9  current column
- y  in  8  current row
- clear_req  in  1  single-cycle pulse, request full clear
- wr_valid  in  1  line client: wr_data valid
- wr_data  in  DATA_W  line client pixel
- wr_last  in  1  line client: final pixel of row
- wr_ready  out  1  scheduler accepts a beat this cycle
- ram_addr  out  ADDR_W  registered RAM address
- ram_wdata  out  DATA_W  registered write data
- ram_we  out  1  registered write enable
- y_offset  out  8  row index displayed at screen top
- busy  out  1  high while clearing
- line_err  out  1  sticky: wr_last mismatch or aborted row; cleared only by reset

## Operation
- States: CLEAR, VIDEO, WRITE, WAIT_END.
- Reset: state CLEAR, clear address 0, ram_addr/ram_wdata/ram_we/y_offset/frame counter/line_err/wr_ready = 0, busy = 1.
- CLEAR: writes 0 to address 0..H_RES*V_RES-1, one per cycle (ram_we=1). After writing the last address: ram_we=0, busy=0, go to VIDEO. y_offset reset to 0 on entry.
- VIDEO: ram_we=0; ram_addr = visible ? x + row*H_RES : 0, with row = y+y_offset, minus V_RES if ≥V_RES. A latched clear_req moves to CLEAR (highest priority). On the first cycle of lower_blank (rising edge), the frame counter increments mod SCROLL_DIV. When it wraps to 0, go to WRITE with col=0 and wrow = (y_offset==0) ? V_RES-1 : y_offset-1.
- WRITE: wr_ready=1. Each beat with wr_valid&wr_ready writes wr_data to wrow*H_RES+col and col increments. At the col==H_RES-1 beat the row is complete: y_offset <= wrow, so the newest row is shown at the top, then go to WAIT_END. If wr_last is asserted at any beat other than col==H_RES-1, or not asserted at that beat, set line_err; the row still ends only at col==H_RES-1.
- Abort: if lower_blank falls while in WRITE, deassert wr_ready, leave y_offset unchanged, set line_err, go to VIDEO. Video always has priority.
- WAIT_END: idle until lower_blank is low, then go to VIDEO.
- A clear_req arriving in WRITE or WAIT_END is latched and taken on the next VIDEO cycle. A clear_req arriving in CLEAR restarts the clear at address 0.
- Arithmetic: row*320 is computed as (row<<8)+(row<<6) at ADDR_W bits. Row wrap uses a compare-subtract, not modulo. The col counter is 9 bits.

## Timing
- Video read: x/y in cycle n gives ram_addr in n+1 and RAM data in n+2. The LCD driver's 2-cycle pipeline compensates for this.
- Write: the beat accepted in cycle n gives ram_addr/ram_wdata/ram_we in n+1.
- wr_ready is a registered state decode. It is never high outside WRITE.
- Clear takes exactly H_RES*V_RES cycles of ram_we=1.
- y_offset updates in the cycle after the final beat, before lower_blank ends.

## Structure
- Shared package/header fb_pkg: H_RES, V_RES, ADDR_W, DATA_W, state encodings.
- One sub-module, fb_row_addr: combinational row wrap plus row*H_RES+col. It is used by both the read path and the write path.

## Test plan
- Reset release -> 76800 consecutive ram_we cycles covering addresses 0..76799 with wdata 0, then busy=0, y_offset=0.
- SCROLL_DIV=4 with a writer that is always valid -> WRITE entered on every 4th lower_blank rise. Row 239 is written at addresses 76480..76799, then y_offset=239; the next row goes to 238.
- visible, x=5, y=10, y_offset=235 -> ram_addr=5+(5*320)=1605 one cycle later.
- Writer stalls so that lower_blank falls at col=100 -> wr_ready drops, y_offset unchanged, line_err=1.
- wr_last asserted at col=200 -> line_err=1; writes continue to col 319.
- clear_req during WRITE -> row completes, then CLEAR starts on the VIDEO cycle after WAIT_END.
